// File: rtl/mem_bram_ctrl_if.sv
// Pipeline-side bus between the MEM stage and the BRAM controller.
// master = MEM stage / pipeline, slave = mem_bram_ctrl.
interface mem_bram_ctrl_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_stall;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_misalign;

    modport master (
        output mem_addr, mem_wr_data, mem_rd, mem_wr,
        input  mem_stall, mem_rd_data, mem_rd_valid, mem_misalign
    );

    modport slave (
        input  mem_addr, mem_wr_data, mem_rd, mem_wr,
        output mem_stall, mem_rd_data, mem_rd_valid, mem_misalign
    );
endinterface

// File: rtl/mem_bram_ctrl.sv
// Single-port BRAM controller: posted writes, stalling fixed-latency reads.
// Optional MEM_ALIGN_CHECK_EN drops misaligned requests and pulses mem_misalign.
module mem_bram_ctrl #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_bram_ctrl_if.slave      mem,
    output logic                bram_en,
    output logic                bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [31:0]         bram_wdata,
    input  logic [31:0]         bram_rdata
);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, RD_DONE} state_t;

    state_t              state_r, state_s;
    logic [2:0]          cnt_r, cnt_s;
    logic                can_accept_s, misalign_s, bad_req_s;
    logic                acc_wr_s, acc_rd_s;
    logic                en_r, en_s, we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [31:0]         wdata_r, wdata_s;
    logic [31:0]         rd_data_r, rd_data_s;
    logic                rd_valid_r, rd_valid_s;
    logic                misalign_r;
    logic                stall_s;
    logic                unused_addr_bits_s;

    // Request acceptance and alignment qualification
    always_comb begin
        can_accept_s = (state_r == IDLE) || (state_r == RD_DONE);
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s   = (mem.mem_addr[1:0] != 2'b00);
`else
        misalign_s   = 1'b0;
`endif
        bad_req_s    = can_accept_s & (mem.mem_rd | mem.mem_wr) & misalign_s;
        acc_wr_s     = can_accept_s & mem.mem_wr & ~misalign_s;
        acc_rd_s     = can_accept_s & mem.mem_rd & ~mem.mem_wr & ~misalign_s;
    end

    // Next-state, counter and next-value logic for all registered outputs
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        rd_data_s  = rd_data_r;
        rd_valid_s = 1'b0;
        en_s       = acc_wr_s | acc_rd_s;
        we_s       = acc_wr_s;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        if (acc_wr_s || acc_rd_s) begin
            addr_s = mem.mem_addr[ADDR_W+1:2];
        end else begin
            addr_s = addr_r;
        end
        if (acc_wr_s) begin
            wdata_s = mem.mem_wr_data;
        end else begin
            wdata_s = wdata_r;
        end
        case (state_r)
            IDLE, RD_DONE: begin
                if (acc_rd_s) begin
                    state_s = RD_ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ISSUE: begin
                state_s = RD_WAIT;
                cnt_s   = 3'(RD_LAT);
            end
            RD_WAIT: begin
                // counter==1 marks the cycle bram_rdata is valid for this read
                if (cnt_r == 3'd1) begin
                    rd_data_s  = bram_rdata;
                    rd_valid_s = 1'b1;
                    cnt_s      = 3'd0;
                    state_s    = RD_DONE;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
        stall_s = (state_r == RD_ISSUE) || (state_r == RD_WAIT) || acc_rd_s;
    end

    // FSM state and wait-counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered BRAM controls and writeback outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_r       <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            rd_data_r  <= 32'h0000_0000;
            rd_valid_r <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            en_r       <= en_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            rd_data_r  <= rd_data_s;
            rd_valid_r <= rd_valid_s;
            misalign_r <= bad_req_s;
        end
    end

    // Byte-offset and high address bits are deliberately ignored (wrap modulo depth)
    assign unused_addr_bits_s = ^{mem.mem_addr[31:ADDR_W+2], mem.mem_addr[1:0]};

    assign bram_en          = en_r;
    assign bram_we          = we_r;
    assign bram_addr        = addr_r;
    assign bram_wdata       = wdata_r;
    assign mem.mem_stall    = stall_s;
    assign mem.mem_rd_data  = rd_data_r;
    assign mem.mem_rd_valid = rd_valid_r;
    assign mem.mem_misalign = misalign_r;

endmodule

// File: tb/tb_mem_bram_ctrl.sv
// Directed self-checking bench for mem_bram_ctrl (ADDR_W=10, RD_LAT=1) with a BRAM model.
// Expectations follow MEM_ALIGN_CHECK_EN when the bench is built with it defined.
module tb_mem_bram_ctrl;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 1;

    logic              clk;
    logic              rst_n;
    logic              bram_en, bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_wdata, bram_rdata;
    logic [31:0]       mem_model [2**ADDR_W];
    logic [31:0]       rd_pipe   [RD_LAT];
    int                n_cmp;
    int                n_err;

    mem_bram_ctrl_if bus ();

    mem_bram_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus.slave),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: data appears RD_LAT cycles after a read enable, garbage otherwise
    always @(posedge clk) begin
        if (bram_en && bram_we) mem_model[bram_addr] <= bram_wdata;
        rd_pipe[0] <= (bram_en && !bram_we) ? mem_model[bram_addr] : 32'h0BAD_0BAD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rdata = rd_pipe[RD_LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_en"},       32'(bram_en), 32'h0);
        check_eq({tag, "_we"},       32'(bram_we), 32'h0);
        check_eq({tag, "_addr"},     32'(bram_addr), 32'h0);
        check_eq({tag, "_wdata"},    bram_wdata, 32'h0);
        check_eq({tag, "_rdata"},    bus.mem_rd_data, 32'h0);
        check_eq({tag, "_valid"},    32'(bus.mem_rd_valid), 32'h0);
        check_eq({tag, "_misalign"}, 32'(bus.mem_misalign), 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        bus.mem_addr = 32'h0;
        bus.mem_wr_data = 32'h0;
        step();
        step();
        check_all_zero("rst");
        check_eq("rst_stall", 32'(bus.mem_stall), 32'h0);
        rst_n = 1'b1;

        // Posted write 0xDEADBEEF @0x10
        bus.mem_wr = 1'b1; bus.mem_addr = 32'h10; bus.mem_wr_data = 32'hDEAD_BEEF;
        #1 check_eq("wr_stall", 32'(bus.mem_stall), 32'h0);
        step();
        check_eq("wr_en", 32'(bram_en), 32'h1);
        check_eq("wr_we", 32'(bram_we), 32'h1);
        check_eq("wr_addr", 32'(bram_addr), 32'h4);
        check_eq("wr_wdata", bram_wdata, 32'hDEAD_BEEF);

        // Read @0x10: stall N..N+2, valid at N+3
        bus.mem_wr = 1'b0; bus.mem_rd = 1'b1; bus.mem_addr = 32'h10;
        #1 check_eq("rd_stall0", 32'(bus.mem_stall), 32'h1);
        step();
        check_eq("rd_issue_en", 32'(bram_en), 32'h1);
        check_eq("rd_issue_we", 32'(bram_we), 32'h0);
        check_eq("rd_issue_addr", 32'(bram_addr), 32'h4);
        check_eq("rd_stall1", 32'(bus.mem_stall), 32'h1);
        step();
        check_eq("rd_wait_en", 32'(bram_en), 32'h0);
        check_eq("rd_stall2", 32'(bus.mem_stall), 32'h1);
        check_eq("rd_wait_valid", 32'(bus.mem_rd_valid), 32'h0);
        step();
        check_eq("rd_valid", 32'(bus.mem_rd_valid), 32'h1);
        check_eq("rd_data", bus.mem_rd_data, 32'hDEAD_BEEF);
        bus.mem_rd = 1'b0;
        #1 check_eq("rd_done_stall", 32'(bus.mem_stall), 32'h0);
        step();
        check_eq("rd_valid_pulse", 32'(bus.mem_rd_valid), 32'h0);
        check_eq("rd_data_hold", bus.mem_rd_data, 32'hDEAD_BEEF);

        // Four back-to-back writes
        for (int k = 0; k < 4; k++) begin
            bus.mem_wr = 1'b1; bus.mem_addr = 32'(k * 4); bus.mem_wr_data = 32'hA0 + 32'(k);
            #1 check_eq($sformatf("b2b_stall%0d", k), 32'(bus.mem_stall), 32'h0);
            step();
            check_eq($sformatf("b2b_en%0d", k), 32'(bram_en & bram_we), 32'h1);
            check_eq($sformatf("b2b_addr%0d", k), 32'(bram_addr), 32'(k));
            check_eq($sformatf("b2b_wdata%0d", k), bram_wdata, 32'hA0 + 32'(k));
        end
        bus.mem_wr = 1'b0;
        step();
        check_eq("b2b_en_off", 32'(bram_en), 32'h0);

        // Simultaneous rd+wr: write wins, read dropped
        bus.mem_rd = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = 32'h20; bus.mem_wr_data = 32'h5;
        #1 check_eq("rw_stall", 32'(bus.mem_stall), 32'h0);
        step();
        check_eq("rw_we", 32'(bram_we), 32'h1);
        check_eq("rw_addr", 32'(bram_addr), 32'h8);
        check_eq("rw_wdata", bram_wdata, 32'h5);
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
        step();
        check_eq("rw_valid", 32'(bus.mem_rd_valid), 32'h0);
        check_eq("rw_en_off", 32'(bram_en), 32'h0);

        // Back-to-back reads: second accepted in RD_DONE
        bus.mem_rd = 1'b1; bus.mem_addr = 32'h0;
        #1 check_eq("bb_stall0", 32'(bus.mem_stall), 32'h1);
        step(); step(); step();
        check_eq("bb_valid0", 32'(bus.mem_rd_valid), 32'h1);
        check_eq("bb_data0", bus.mem_rd_data, 32'hA0);
        bus.mem_addr = 32'h4;
        #1 check_eq("bb_stall1", 32'(bus.mem_stall), 32'h1);
        step();
        check_eq("bb_issue_valid", 32'(bus.mem_rd_valid), 32'h0);
        check_eq("bb_issue_en", 32'(bram_en), 32'h1);
        check_eq("bb_issue_addr", 32'(bram_addr), 32'h1);
        step(); step();
        check_eq("bb_valid1", 32'(bus.mem_rd_valid), 32'h1);
        check_eq("bb_data1", bus.mem_rd_data, 32'hA1);
        bus.mem_rd = 1'b0;
        #1 check_eq("bb_stall_end", 32'(bus.mem_stall), 32'h0);
        step();

        // Misaligned / out-of-range address 0x1002
        bus.mem_wr = 1'b1; bus.mem_addr = 32'h1002; bus.mem_wr_data = 32'hCAFE_0077;
        #1 check_eq("ma_stall", 32'(bus.mem_stall), 32'h0);
        step();
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("ma_misalign", 32'(bus.mem_misalign), 32'h1);
        check_eq("ma_en", 32'(bram_en), 32'h0);
`else
        check_eq("ma_misalign", 32'(bus.mem_misalign), 32'h0);
        check_eq("ma_en", 32'(bram_en & bram_we), 32'h1);
        check_eq("ma_addr", 32'(bram_addr), 32'h0);
`endif
        bus.mem_wr = 1'b0;
        step();
        check_eq("ma_misalign_off", 32'(bus.mem_misalign), 32'h0);
        bus.mem_rd = 1'b1; bus.mem_addr = 32'h0;
        step(); step(); step();
        bus.mem_rd = 1'b0;
        check_eq("ma_rd_valid", 32'(bus.mem_rd_valid), 32'h1);
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("ma_rd_data", bus.mem_rd_data, 32'hA0);
`else
        check_eq("ma_rd_data", bus.mem_rd_data, 32'hCAFE_0077);
`endif
        step();

        // Reset held 3 cycles in the middle of a read
        bus.mem_rd = 1'b1; bus.mem_addr = 32'h4;
        step();
        bus.mem_rd = 1'b0;
        rst_n = 1'b0;
        step(); step(); step();
        check_all_zero("rst_mid");
        check_eq("rst_mid_stall", 32'(bus.mem_stall), 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("rst_post_valid0", 32'(bus.mem_rd_valid), 32'h0);
        step();
        check_eq("rst_post_valid1", 32'(bus.mem_rd_valid), 32'h0);
        check_eq("rst_post_data", bus.mem_rd_data, 32'h0);

        // Fresh read after reset proves the FSM restarted from IDLE
        bus.mem_rd = 1'b1; bus.mem_addr = 32'h20;
        #1 check_eq("post_stall", 32'(bus.mem_stall), 32'h1);
        step(); step(); step();
        check_eq("post_valid", 32'(bus.mem_rd_valid), 32'h1);
        check_eq("post_data", bus.mem_rd_data, 32'h5);
        bus.mem_rd = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
